// File: rtl/cpu_control_sequencer_if.sv
// Memory and ALU bus of the accumulator machine sequencer.
// master = sequencer side, slave = memory/ALU side.
interface cpu_control_sequencer_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_op1;
  logic [15:0] alu_op2;
  logic [15:0] alu_result;

  modport master (
    output mem_addr, mem_wdata, mem_we,
    output alu_opcode, alu_op1, alu_op2,
    input  mem_rdata, alu_result
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we,
    input  alu_opcode, alu_op1, alu_op2,
    output mem_rdata, alu_result
  );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute controller for the 16-bit accumulator machine.
// Owns pc, ir and acc; one memory transaction per state.
module cpu_control_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  cpu_control_sequencer_if.master bus,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [15:0] acc,
  output logic        halted,
  output logic        illegal,
  output logic        retire
);

  typedef enum logic [2:0] {
    FETCH, LATCH, DECODE, EXEC, HALT
  } state_t;

  state_t      state, state_nx;
  logic [15:0] pc_nx, ir_nx, acc_nx;
  logic        halted_nx, illegal_nx;
  logic [3:0]  opc;
  logic [15:0] ea;
  logic [3:0]  alu_code;

  assign opc           = ir[15:12];
  assign ea            = {4'h0, ir[11:0]};
  assign bus.mem_wdata = acc;
  assign bus.alu_op1   = acc;
  assign bus.alu_op2   = bus.mem_rdata;

  always_comb begin
    alu_code = 4'b0000;
    unique case (opc)
      4'h4:    alu_code = 4'b0001;
      4'h5:    alu_code = 4'b1000;
      4'h6:    alu_code = 4'b1001;
      4'h7:    alu_code = 4'b1010;
      4'h8:    alu_code = 4'b0100;
      4'h9:    alu_code = 4'b0101;
      default: alu_code = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= 16'h0000;
      acc     <= 16'h0000;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      ir      <= ir_nx;
      acc     <= acc_nx;
      halted  <= halted_nx;
      illegal <= illegal_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    ir_nx          = ir;
    acc_nx         = acc;
    halted_nx      = halted;
    illegal_nx     = illegal;
    bus.mem_addr   = pc;
    bus.mem_we     = 1'b0;
    bus.alu_opcode = 4'b0000;
    retire         = 1'b0;
    unique case (state)
      FETCH: state_nx = LATCH;
      LATCH: begin
        ir_nx    = bus.mem_rdata;
        pc_nx    = pc + 16'h0001;
        state_nx = DECODE;
      end
      DECODE: begin
        bus.alu_opcode = alu_code;
        state_nx       = FETCH;
        unique case (opc)
          4'h0: begin
            halted_nx = 1'b1;
            retire    = 1'b1;
            state_nx  = HALT;
          end
          4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            bus.mem_addr = ea;
            state_nx     = EXEC;
          end
          4'h2: begin
            bus.mem_addr = ea;
            bus.mem_we   = 1'b1;
            retire       = 1'b1;
          end
          4'h8, 4'h9: begin
            acc_nx = bus.alu_result;
            retire = 1'b1;
          end
          4'hA: begin
            pc_nx  = ea;
            retire = 1'b1;
          end
          4'hB: begin
            if (acc == 16'h0000) pc_nx = ea;
            retire = 1'b1;
          end
          4'hC: begin
            acc_nx = ea;
            retire = 1'b1;
          end
          default: begin
            halted_nx  = 1'b1;
            illegal_nx = 1'b1;
            state_nx   = HALT;
          end
        endcase
      end
      EXEC: begin
        bus.alu_opcode = alu_code;
        acc_nx   = (opc == 4'h1) ? bus.mem_rdata : bus.alu_result;
        retire   = 1'b1;
        state_nx = FETCH;
      end
      HALT: state_nx = HALT;
      default: state_nx = FETCH;
    endcase
    // reset must block a write already decoded this cycle
    if (reset) begin
      bus.mem_we = 1'b0;
      retire     = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer with behavioural memory and ALU.
// Two instances: default reset pc and reset pc FFFF.
module tb_cpu_control_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int nv = 0;
  int nf = 0;

  cpu_control_sequencer_if b0();
  cpu_control_sequencer_if b1();

  logic [15:0] pc0, ir0, acc0, pc1, ir1, acc1;
  logic        hlt0, ill0, ret0, hlt1, ill1, ret1;

  cpu_control_sequencer #(.RESET_PC(16'h0000)) dut0 (
    .clk(clk), .reset(reset), .bus(b0),
    .pc(pc0), .ir(ir0), .acc(acc0),
    .halted(hlt0), .illegal(ill0), .retire(ret0)
  );

  cpu_control_sequencer #(.RESET_PC(16'hFFFF)) dut1 (
    .clk(clk), .reset(reset), .bus(b1),
    .pc(pc1), .ir(ir1), .acc(acc1),
    .halted(hlt1), .illegal(ill1), .retire(ret1)
  );

  logic [15:0] m0 [0:65535];
  logic [15:0] m1 [0:65535];
  logic        ld_we = 1'b0;
  logic [15:0] ld_addr = 16'h0;
  logic [15:0] ld_data = 16'h0;

  always @(posedge clk) begin
    if (ld_we) begin
      m0[ld_addr] <= ld_data;
      m1[ld_addr] <= ld_data;
    end else begin
      if (b0.mem_we) m0[b0.mem_addr] <= b0.mem_wdata;
      if (b1.mem_we) m1[b1.mem_addr] <= b1.mem_wdata;
    end
    b0.mem_rdata <= m0[b0.mem_addr];
    b1.mem_rdata <= m1[b1.mem_addr];
  end

  function automatic logic [15:0] alu(input logic [3:0] op,
                                      input logic [15:0] a,
                                      input logic [15:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0100: return {a[14:0], 1'b0};
      4'b0101: return {1'b0, a[15:1]};
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  assign b0.alu_result = alu(b0.alu_opcode, b0.alu_op1, b0.alu_op2);
  assign b1.alu_result = alu(b1.alu_opcode, b1.alu_op1, b1.alu_op2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    ld_addr = a;
    ld_data = d;
    ld_we   = 1'b1;
    tick();
    ld_we   = 1'b0;
  endtask

  task automatic begin_run();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nv++;
      if ({pc0, acc0, ir0} !== 48'h0) begin
        nf++;
        $display("FAIL reset_regs cyc%0d got pc=%h acc=%h ir=%h want 0000 0000 0000",
                 i, pc0, acc0, ir0);
      end
      nv++;
      if (hlt0 !== 1'b0 || b0.mem_we !== 1'b0 || ret0 !== 1'b0) begin
        nf++;
        $display("FAIL reset_ctl cyc%0d got halted=%b we=%b retire=%b want 0 0 0",
                 i, hlt0, b0.mem_we, ret0);
      end
    end
    reset = 1'b0;
    #1;
    nv++;
    if (b0.mem_addr !== 16'h0000) begin
      nf++;
      $display("FAIL first_fetch_addr got %h want 0000", b0.mem_addr);
    end
  endtask

  task automatic test_load_add_store();
    int cyc = 0;
    int nret = 0;
    reset = 1'b1;
    poke(16'h0000, 16'h1010);
    poke(16'h0001, 16'h3011);
    poke(16'h0002, 16'h2012);
    poke(16'h0003, 16'h0000);
    poke(16'h0010, 16'h0005);
    poke(16'h0011, 16'h0007);
    poke(16'h0012, 16'h0000);
    begin_run();
    while (!hlt0 && cyc < 100) begin
      if (ret0) nret++;
      tick();
      cyc++;
    end
    nv++;
    if (cyc !== 14) begin
      nf++; $display("FAIL las_cycles got %0d want 14", cyc);
    end
    nv++;
    if (nret !== 4) begin
      nf++; $display("FAIL las_retires got %0d want 4", nret);
    end
    nv++;
    if (acc0 !== 16'h000C) begin
      nf++; $display("FAIL las_acc got %h want 000C", acc0);
    end
    nv++;
    if (m0[16'h0012] !== 16'h000C) begin
      nf++; $display("FAIL las_store got %h want 000C", m0[16'h0012]);
    end
    nv++;
    if (pc0 !== 16'h0004 || ill0 !== 1'b0) begin
      nf++; $display("FAIL las_pc got pc=%h ill=%b want 0004 0", pc0, ill0);
    end
  endtask

  task automatic test_jz_shift();
    int cyc = 0;
    int nret = 0;
    logic bad = 1'b0;
    reset = 1'b1;
    poke(16'h0000, 16'hC000);
    poke(16'h0001, 16'hB005);
    poke(16'h0002, 16'hC0AA);
    poke(16'h0003, 16'hC0BB);
    poke(16'h0004, 16'hC0CC);
    poke(16'h0005, 16'hC0FF);
    poke(16'h0006, 16'h8000);
    poke(16'h0007, 16'h0000);
    begin_run();
    while (!hlt0 && cyc < 100) begin
      if (ret0) nret++;
      if (ir0 == 16'hC0AA || ir0 == 16'hC0BB || ir0 == 16'hC0CC) bad = 1'b1;
      tick();
      cyc++;
    end
    nv++;
    if (acc0 !== 16'h01FE) begin
      nf++; $display("FAIL jz_acc got %h want 01FE", acc0);
    end
    nv++;
    if (pc0 !== 16'h0008) begin
      nf++; $display("FAIL jz_pc got %h want 0008", pc0);
    end
    nv++;
    if (bad !== 1'b0) begin
      nf++; $display("FAIL jz_skipped got fetched=%b want 0", bad);
    end
    nv++;
    if (cyc !== 15 || nret !== 5) begin
      nf++; $display("FAIL jz_timing got cyc=%0d ret=%0d want 15 5", cyc, nret);
    end
  endtask

  task automatic test_illegal();
    int cyc = 0;
    int nret = 0;
    reset = 1'b1;
    poke(16'h0000, 16'hE123);
    begin_run();
    while (!hlt0 && cyc < 100) begin
      if (ret0) nret++;
      tick();
      cyc++;
    end
    nv++;
    if (cyc !== 3 || nret !== 0) begin
      nf++; $display("FAIL ill_timing got cyc=%0d ret=%0d want 3 0", cyc, nret);
    end
    nv++;
    if (ill0 !== 1'b1 || acc0 !== 16'h0000) begin
      nf++; $display("FAIL ill_flag got ill=%b acc=%h want 1 0000", ill0, acc0);
    end
    for (int i = 0; i < 5; i++) begin
      if (ret0) nret++;
      tick();
    end
    nv++;
    if (pc0 !== 16'h0001 || hlt0 !== 1'b1 || ir0 !== 16'hE123 || nret !== 0) begin
      nf++;
      $display("FAIL ill_frozen got pc=%h h=%b ir=%h ret=%0d want 0001 1 E123 0",
               pc0, hlt0, ir0, nret);
    end
  endtask

  task automatic test_pc_wrap();
    int cyc = 0;
    int nret = 0;
    reset = 1'b1;
    poke(16'hFFFF, 16'hC001);
    poke(16'h0000, 16'h0000);
    begin_run();
    nv++;
    if (b1.mem_addr !== 16'hFFFF) begin
      nf++; $display("FAIL wrap_fetch got %h want FFFF", b1.mem_addr);
    end
    while (!hlt1 && cyc < 100) begin
      if (ret1) nret++;
      tick();
      cyc++;
      if (cyc == 2) begin
        nv++;
        if (pc1 !== 16'h0000) begin
          nf++; $display("FAIL wrap_pc got %h want 0000", pc1);
        end
      end
    end
    nv++;
    if (acc1 !== 16'h0001 || pc1 !== 16'h0001) begin
      nf++; $display("FAIL wrap_halt got acc=%h pc=%h want 0001 0001", acc1, pc1);
    end
    nv++;
    if (cyc !== 6 || nret !== 2) begin
      nf++; $display("FAIL wrap_timing got cyc=%0d ret=%0d want 6 2", cyc, nret);
    end
  endtask

  task automatic test_reset_mid_store();
    reset = 1'b1;
    poke(16'h0000, 16'h1020);
    poke(16'h0001, 16'h2012);
    poke(16'h0012, 16'h1111);
    poke(16'h0020, 16'hABCD);
    begin_run();
    for (int i = 0; i < 6; i++) tick();
    nv++;
    if (acc0 !== 16'hABCD || ir0 !== 16'h2012 || b0.mem_we !== 1'b1) begin
      nf++;
      $display("FAIL mid_setup got acc=%h ir=%h we=%b want ABCD 2012 1",
               acc0, ir0, b0.mem_we);
    end
    reset = 1'b1;
    #1;
    nv++;
    if (b0.mem_we !== 1'b0 || ret0 !== 1'b0) begin
      nf++; $display("FAIL mid_we got we=%b ret=%b want 0 0", b0.mem_we, ret0);
    end
    tick();
    nv++;
    if (m0[16'h0012] !== 16'h1111) begin
      nf++; $display("FAIL mid_mem got %h want 1111", m0[16'h0012]);
    end
    nv++;
    if (pc0 !== 16'h0000 || acc0 !== 16'h0000 || ir0 !== 16'h0000 ||
        b0.mem_addr !== 16'h0000 || hlt0 !== 1'b0) begin
      nf++;
      $display("FAIL mid_regs got pc=%h acc=%h ir=%h addr=%h h=%b want 0 0 0 0 0",
               pc0, acc0, ir0, b0.mem_addr, hlt0);
    end
    reset = 1'b0;
    tick();
    nv++;
    if (ir0 !== 16'h0000 || pc0 !== 16'h0000) begin
      nf++; $display("FAIL mid_fetch got ir=%h pc=%h want 0000 0000", ir0, pc0);
    end
    tick();
    nv++;
    if (ir0 !== 16'h1020 || pc0 !== 16'h0001) begin
      nf++; $display("FAIL mid_latch got ir=%h pc=%h want 1020 0001", ir0, pc0);
    end
  endtask

  initial begin
    test_reset();
    test_load_add_store();
    test_jz_shift();
    test_illegal();
    test_pc_wrap();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end

endmodule

// File: doc/cpu_control_sequencer.md
# cpu_control_sequencer

Fetch–decode–execute controller for the 16-bit accumulator machine. It owns the program counter, instruction register and accumulator, and drives the synchronous main memory port and the combinational ALU. It issues one memory transaction per state and retires one instruction every 3 or 4 cycles until it halts.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high.
- mem_addr  out  16  memory address, combinational from state.
- mem_wdata  out  16  write data; always equals acc.
- mem_we  out  1  memory write enable, combinational, forced 0 while reset=1.
- mem_rdata  in  16  memory read data; valid the cycle after the address is presented.
- alu_opcode  out  4  ALU operation select.
- alu_op1  out  16  ALU operand 1; always acc.
- alu_op2  out  16  ALU operand 2; always mem_rdata.
- alu_result  in  16  combinational ALU result.
- pc  out  16  program counter (debug/observe).
- ir  out  16  instruction register.
- acc  out  16  accumulator.
- halted  out  1  high once HALT or an illegal opcode executes; sticky until reset.
- illegal  out  1  high if the halt was caused by opcode 0xD–0xF; sticky until reset.
- retire  out  1  one-cycle pulse in the final cycle of each instruction.

## Operation
- Instruction format: ir[15:12] is the opcode. ir[11:0] is the address or immediate, zero-extended to 16 bits and called EA below.
- Opcodes:
  - 0x0 HALT.
  - 0x1 LOAD: acc<=M[EA].
  - 0x2 STORE: M[EA]<=acc.
  - 0x3 ADD (ALU 0000), 0x4 SUB (0001), 0x5 AND (1000), 0x6 OR (1001), 0x7 XOR (1010): acc<=alu_result with op2=M[EA].
  - 0x8 SHL (ALU 0100): acc<=acc<<1. 0x9 SHR (ALU 0101): acc<=acc>>1. Neither accesses memory.
  - 0xA JMP: pc<=EA. 0xB JZ: if acc==0 then pc<=EA.
  - 0xC LDI: acc<=EA.
  - 0xD–0xF: illegal.
- States: FETCH, LATCH, DECODE, EXEC, HALT.
  - FETCH: mem_addr=pc, mem_we=0. Next state LATCH.
  - LATCH: ir<=mem_rdata, pc<=pc+1 (16-bit, FFFF wraps to 0000 silently). Next state DECODE.
  - DECODE, memory-operand ops (LOAD, ADD..XOR): mem_addr=EA. Next state EXEC.
  - DECODE, STORE: mem_addr=EA, mem_we=1. retire=1. Next state FETCH.
  - DECODE, SHL/SHR/JMP/JZ/LDI: perform the update. retire=1. Next state FETCH.
  - DECODE, HALT or illegal: halted<=1; illegal<=1 for 0xD–0xF. retire=1 for HALT only. Next state HALT.
  - EXEC: acc<=mem_rdata for LOAD, or acc<=alu_result for ADD..XOR. retire=1. Next state FETCH.
  - HALT: absorbing. mem_we=0 and pc/acc/ir are frozen; only reset leaves it.
- alu_opcode = table value for the decoded op in DECODE/EXEC; 4'b0000 otherwise.
- mem_addr in LATCH, EXEC and HALT: holds the last driven value is not required, drive pc.
- JZ tests acc as it stands at DECODE; a JMP/JZ overwrites the LATCH increment.

## Timing
- Reset values (registered, the cycle after reset sampled high):
  - state=FETCH, pc=RESET_PC, ir=0, acc=0, halted=0, illegal=0.
  - retire=0, mem_we=0, mem_addr=RESET_PC.
- Instruction latency from FETCH entry to retire:
  - 4 cycles: LOAD, ADD..XOR.
  - 3 cycles: STORE, SHL, SHR, JMP, JZ, LDI, HALT.
- Memory read: the address is driven in cycle N; the sequencer samples mem_rdata in cycle N+1, at the edge ending N+1. The sequencer never reads and writes in the same cycle.
- STORE followed immediately by a FETCH of the same address returns the newly written data, because the write commits at the end of DECODE.
- Reset asserted in any state, including mid-STORE:
  - mem_we is 0 in that cycle, so no write reaches memory.
  - All registers take reset values at the next edge.
- retire and the architectural update occur in the same cycle; register values are visible the following cycle.

## Test plan
- Reset then hold reset for 3 cycles -> pc=0000, acc=0, ir=0, halted=0, mem_we never 1; first FETCH drives mem_addr=0000 the cycle reset falls.
- Program M[0]=1010 (LOAD 010), M[1]=3011 (ADD 011), M[2]=2012 (STORE 012), M[3]=0000, with M[010]=0005, M[011]=0007 -> M[012]=000C, acc=000C, halted=1 after exactly 4+4+3+3=14 cycles, retire pulsed 4 times.
- M[0]=C000 (LDI 0), M[1]=B005 (JZ 005), M[5]=C0FF, M[6]=8000 (SHL), M[7]=0000 -> acc=01FE, pc=0008 at halt, M[2..4] never fetched.
- M[0]=E123 -> halted=1, illegal=1, no retire, acc unchanged 0, pc=0001 thereafter regardless of further clocks.
- Preload pc via RESET_PC=FFFF with M[FFFF]=C001, M[0000]=0000 -> acc=0001, pc wraps to 0000, halts with pc=0001.
- Assert reset during DECODE of STORE 012 with acc=ABCD -> M[012] unchanged, next cycle pc=0000, acc=0000, state FETCH.
